// File: rtl/cnt_display_pkg.sv
// Shared types and constants for the two-digit multiplexed count display.
// The state enum, the 7-segment table and the blank/off codes live here so the decoder and the top agree.
package cnt_display_pkg;

    typedef enum logic [1:0] {
        S_BLANK0 = 2'd0,
        S_ONES   = 2'd1,
        S_BLANK1 = 2'd2,
        S_TENS   = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] DIG_OFF   = 2'b11;
    localparam logic [1:0] DIG_ONES  = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [3:0] ones_of(input logic [3:0] value);
        return (value >= 4'd10) ? value - 4'd10 : value;
    endfunction

    function automatic logic tens_of(input logic [3:0] value);
        return (value >= 4'd10);
    endfunction

endpackage

// File: rtl/cnt_display_seg7_dec.sv
// Combinational decimal-digit to active-low 7-segment decoder.
// Codes above 9 cannot come from the decimal split; they decode to all segments off.
module seg7_dec
    import cnt_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (digit < 4'd10) begin
            seg_n = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/cnt_display.sv
// Two-digit multiplexed display of a 4-bit counter, with blanking gaps between digits.
// Optional leading-zero blanking of the tens digit is enabled with macro CNT_DISPLAY_LZB_EN.
//
// state    | meaning
// S_BLANK0 | both digits off; leaving it latches the new frame value
// S_ONES   | ones digit driven for SCAN_DIV cycles
// S_BLANK1 | both digits off between ones and tens
// S_TENS   | tens digit driven for SCAN_DIV cycles
module cnt_display
    import cnt_display_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cnt_in,
    output logic [6:0] seg_n,
    output logic [1:0] dig_n,
    output logic       disp_chg
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [3:0]    cnt_q;
    logic [3:0]    disp_q;
    logic [3:0]    disp_nx;
    logic          phase_last;
    logic          load;
    logic [3:0]    digit_sel;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_d;
    logic [1:0]    dig_d;

    always_comb begin
        if ((state == S_ONES) || (state == S_TENS)) begin
            phase_last = (timer == SCAN_LAST);
        end else begin
            phase_last = (timer == BLANK_LAST);
        end

        state_nx = state;
        if (phase_last) begin
            case (state)
                S_BLANK0: state_nx = S_ONES;
                S_ONES:   state_nx = S_BLANK1;
                S_BLANK1: state_nx = S_TENS;
                S_TENS:   state_nx = S_BLANK0;
                default:  state_nx = S_BLANK0;
            endcase
        end
    end

    // The frame value is captured only when the ones digit starts, so a frame never tears
    assign load    = (state == S_BLANK0) && (state_nx == S_ONES);
    assign disp_nx = load ? cnt_q : disp_q;

    assign digit_sel = (state_nx == S_TENS) ? {3'b000, tens_of(disp_nx)} : ones_of(disp_nx);

    seg7_dec u_seg7_dec (
        .digit (digit_sel),
        .seg_n (seg_dec)
    );

    // Outputs are computed from the next state so the registered pins line up with the state register
    always_comb begin
        seg_d = SEG_BLANK;
        dig_d = DIG_OFF;
        case (state_nx)
            S_ONES: begin
                seg_d = seg_dec;
                dig_d = DIG_ONES;
            end
            S_TENS: begin
`ifdef CNT_DISPLAY_LZB_EN
                if (tens_of(disp_nx)) begin
                    seg_d = seg_dec;
                    dig_d = DIG_TENS;
                end
`else
                seg_d = seg_dec;
                dig_d = DIG_TENS;
`endif
            end
            default: begin
                seg_d = SEG_BLANK;
                dig_d = DIG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BLANK0;
            timer    <= '0;
            cnt_q    <= 4'd0;
            disp_q   <= 4'd0;
            disp_chg <= 1'b0;
            seg_n    <= SEG_BLANK;
            dig_n    <= DIG_OFF;
        end else begin
            cnt_q    <= cnt_in;
            state    <= state_nx;
            timer    <= (state_nx != state) ? '0 : timer + 1'b1;
            disp_q   <= disp_nx;
            disp_chg <= load && (cnt_q != disp_q);
            seg_n    <= seg_d;
            dig_n    <= dig_d;
        end
    end

endmodule

// File: doc/cnt_display.md
CNT_DISPLAY -- requirements
Module: cnt_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, giving clock cycles per digit-on phase (legal range 1..255).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1, giving clock cycles per inter-digit blanking phase (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 The block SHALL have port cnt_in, input, 4 bits, unsigned count value from the upstream 4-bit counter (0..15).
REQ-006 The block SHALL have port seg_n, output, 7 bits, active-low segments {g,f,e,d,c,b,a}, registered.
REQ-007 The block SHALL have port dig_n, output, 2 bits, active-low digit enables; bit 0 = ones, bit 1 = tens; registered.
REQ-008 The block SHALL have port disp_chg, output, 1 bit, a one-cycle pulse when the displayed value changes.

Function
REQ-009 cnt_in SHALL be sampled into cnt_q on every clock edge (1-cycle input register).
REQ-010 Scan FSM states SHALL be S_BLANK0 -> S_ONES -> S_BLANK1 -> S_TENS -> S_BLANK0, cyclic, no other transitions.
REQ-011 Each S_ONES/S_TENS SHALL last exactly SCAN_DIV cycles; each S_BLANK0/S_BLANK1 exactly BLANK_CYC cycles; frame = 2*(SCAN_DIV+BLANK_CYC) cycles.
REQ-012 On the transition S_BLANK0 -> S_ONES, disp_q SHALL load cnt_q; disp_q SHALL be held for the rest of the frame (no mid-frame tearing).
REQ-013 disp_chg SHALL be 1 for exactly the cycle after a disp_q load whose new value differs from its previous value, else 0.
REQ-014 Decimal split: ones = disp_q mod 10, tens = disp_q / 10 (tens is 0 or 1 only).
REQ-015 In S_ONES: dig_n = 2'b10, seg_n = encoding of ones; in S_TENS: dig_n = 2'b01, seg_n = encoding of tens.
REQ-016 In S_BLANK0/S_BLANK1: dig_n = 2'b11, seg_n = 7'h7F; never both digits enabled in any cycle.
REQ-017 Encodings (active-low gfedcba): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-018 Wrap-around 15 -> 0 on cnt_in SHALL be handled as an ordinary value change (display "15" then "00" at next frame boundary).
REQ-019 Phase timer SHALL be $clog2-sized for max(SCAN_DIV, BLANK_CYC) and reload to 0 on each state transition.

Reset
REQ-020 While rst_n = 0: seg_n = 7'h7F, dig_n = 2'b11, disp_chg = 0, cnt_q = 0, disp_q = 0, timer = 0, state = S_BLANK0, asynchronously.
REQ-021 After rst_n rises, first S_ONES SHALL begin BLANK_CYC cycles later; reset mid-frame SHALL abort the frame with no residual digit enable.

Configuration
REQ-022 Macro CNT_DISPLAY_LZB_EN SHALL enable leading-zero blanking: when defined and tens = 0, S_TENS drives seg_n = 7'h7F and dig_n = 2'b11.
REQ-023 Without CNT_DISPLAY_LZB_EN, S_TENS with tens = 0 SHALL display 0x40 with dig_n = 2'b01; timing identical in both builds.

Structure
REQ-024 Package cnt_display_pkg SHALL hold the state enum, the 10-entry segment constant table, SEG_BLANK = 7'h7F and DIG_OFF = 2'b11.
REQ-025 Sub-module seg7_dec (combinational, 4-bit digit in, 7-bit active-low segments out) SHALL be used for the decode; output registering stays in cnt_display.

Verification (SCAN_DIV=4, BLANK_CYC=1, frame = 10 cycles)
REQ-026 Hold cnt_in=12 -> every frame: 4 cycles seg_n=0x24/dig_n=2'b10, 1 blank, 4 cycles seg_n=0x79/dig_n=2'b01, 1 blank.
REQ-027 Step cnt_in 15 -> 0 -> next frame shows ones 0x40, tens 0x40 (LZB off) or tens blanked with dig_n=2'b11 (LZB on); disp_chg pulses once.
REQ-028 Change cnt_in 3 -> 7 during S_TENS -> remainder of frame unchanged; next S_ONES shows 0x78; disp_chg = 1 for one cycle.
REQ-029 Drive rst_n low mid-S_ONES -> seg_n=0x7F, dig_n=2'b11 before next clock edge; after release, first S_ONES after 1 cycle shows 0x40.
REQ-030 Free-running upstream counter for 2000 cycles -> checker: dig_n never 2'b00, phase lengths exact, disp_chg count equals distinct frame-boundary value changes.
